multirate_v2_mac_pipe: RTL and testbench

//  Pipelined signed multiply-accumulate unit for the multirate FIR filterbank datapath.

---
 rtl/multirate_v2_mac_pipe.sv | 156 +++++++++++++++
 tb/tb_multirate_v2_mac_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multirate_v2_mac_pipe.sv
// Pipelined signed MAC for the multirate FIR filterbank.
// Mode 0 multiplies, mode 1 accumulates framed taps; rounded, saturated output.
module multirate_v2_mac_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 24,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0,
  parameter int SAT        = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  in_vld,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  mode,
  input  logic                  acc_clr,
  input  logic                  acc_last,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic                  ovf
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int XW = ACC_WIDTH + 1;

  localparam logic signed [XW-1:0] RND =
    XW'((64'd1 << SHIFT) >> 1);
  localparam logic signed [XW-1:0] MAXV =
    XW'((64'd1 << (DOUT_WIDTH-1)) - 64'd1);
  localparam logic signed [XW-1:0] MINV = ~MAXV;

  typedef struct packed {
    logic          vld;
    logic          mode;
    logic          clr;
    logic          last;
    logic [PW-1:0] p;
  } stage_t;

  logic signed [PW-1:0]        a_ext;
  logic signed [PW-1:0]        b_ext;
  logic signed [PW-1:0]        p_in;
  stage_t                      st_in;
  stage_t                      tail;
  logic signed [ACC_WIDTH-1:0] p_ext;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_nxt;
  logic                        emit;
  logic                        m0;
  logic [DOUT_WIDTH:0]         f_acc;
  logic [DOUT_WIDTH:0]         f_p;

  // Round half up, shift, then clamp or wrap; MSB of result is the overflow flag.
  function automatic logic [DOUT_WIDTH:0] fmt(
    input logic signed [ACC_WIDTH-1:0] x
  );
    logic signed [XW-1:0] xr;
    logic                 hi;
    logic                 lo;
    logic [DOUT_WIDTH-1:0] d;
    xr = XW'(x);
    xr = (xr + RND) >>> SHIFT;
    hi = xr > MAXV;
    lo = xr < MINV;
    d  = xr[DOUT_WIDTH-1:0];
    if (SAT != 0) begin
      if (hi) d = MAXV[DOUT_WIDTH-1:0];
      if (lo) d = MINV[DOUT_WIDTH-1:0];
    end
    return {hi | lo, d};
  endfunction

  assign a_ext = PW'($signed(din0));
  assign b_ext = PW'($signed(din1));
  assign p_in  = a_ext * b_ext;

  // Bundle the incoming sample with its product and framing bits.
  always_comb begin
    st_in      = '0;
    st_in.vld  = in_vld;
    st_in.mode = mode;
    st_in.clr  = acc_clr;
    st_in.last = acc_last;
    st_in.p    = p_in;
  end

  generate
    if (NUM_STAGE == 1) begin : g_nopipe
      assign tail = st_in;
    end else begin : g_pipe
      stage_t pipe [NUM_STAGE-1];

      // Product delay line; the output register supplies the final stage.
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          for (int k = 0; k < NUM_STAGE-1; k++)
            pipe[k] <= '0;
        end else if (ce) begin
          pipe[0] <= st_in;
          for (int k = 1; k < NUM_STAGE-1; k++)
            pipe[k] <= pipe[k-1];
        end
      end

      assign tail = pipe[NUM_STAGE-2];
    end
  endgenerate

  assign p_ext = ACC_WIDTH'($signed(tail.p));
  assign m0    = tail.vld & ~tail.mode;

  // Next accumulator value: restart on first tap, else add and wrap.
  always_comb begin
    acc_nxt = p_ext;
    if (!tail.clr)
      acc_nxt = acc + p_ext;
  end

  // Accumulator stage; only mode-1 samples touch it.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc  <= '0;
      emit <= 1'b0;
    end else if (ce) begin
      emit <= tail.vld & tail.mode & tail.last;
      if (tail.vld & tail.mode)
        acc <= acc_nxt;
    end
  end

  assign f_acc = fmt(acc);
  assign f_p   = fmt(p_ext);

  // Output register; a finished frame outranks a same-cycle product.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else if (ce) begin
      dout_vld <= emit | m0;
      ovf      <= 1'b0;
      if (emit) begin
        dout <= f_acc[DOUT_WIDTH-1:0];
        ovf  <= f_acc[DOUT_WIDTH];
      end else if (m0) begin
        dout <= f_p[DOUT_WIDTH-1:0];
        ovf  <= f_p[DOUT_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_multirate_v2_mac_pipe.sv
// Scoreboard bench for multirate_v2_mac_pipe.
// Three builds (default, SAT=0, SHIFT=4) share one stimulus bus.
module tb_multirate_v2_mac_pipe;

  logic        clk = 1'b0;
  logic        ap_rst;
  logic        ce;
  logic        in_vld;
  logic [15:0] din0;
  logic [7:0]  din1;
  logic        mode;
  logic        acc_clr;
  logic        acc_last;

  logic [23:0] dout0, dout1, dout2;
  logic        vld0, vld1, vld2;
  logic        ovf0, ovf1, ovf2;

  typedef struct {
    int cyc;
    int val;
    bit ovf;
  } exp_t;

  exp_t sb [3][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   issue  = 0;

  always #5 clk = ~clk;

  multirate_v2_mac_pipe u_d0 (
    .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .in_vld(in_vld),
    .din0(din0), .din1(din1), .mode(mode),
    .acc_clr(acc_clr), .acc_last(acc_last),
    .dout(dout0), .dout_vld(vld0), .ovf(ovf0)
  );

  multirate_v2_mac_pipe #(.SAT(0)) u_d1 (
    .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .in_vld(in_vld),
    .din0(din0), .din1(din1), .mode(mode),
    .acc_clr(acc_clr), .acc_last(acc_last),
    .dout(dout1), .dout_vld(vld1), .ovf(ovf1)
  );

  multirate_v2_mac_pipe #(.SHIFT(4)) u_d2 (
    .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .in_vld(in_vld),
    .din0(din0), .din1(din1), .mode(mode),
    .acc_clr(acc_clr), .acc_last(acc_last),
    .dout(dout2), .dout_vld(vld2), .ovf(ovf2)
  );

  // Monitor: pop and compare on every strobe produced by an enabled edge.
  task automatic mon(input int i, input logic v,
                     input logic [23:0] d, input logic o);
    exp_t e;
    int   got;
    got = int'($signed(d));
    checks++;
    if (!v) begin
      if (o !== 1'b0) begin
        errors++;
        $display("FAIL ovf_idle dut%0d cyc %0d got %0b want 0",
                 i, cyc, o);
      end
    end else if (sb[i].size() == 0) begin
      errors++;
      $display("FAIL unexpected_strobe dut%0d cyc %0d dout %0d",
               i, cyc, got);
    end else begin
      e = sb[i].pop_front();
      if (e.cyc != cyc || e.val != got || e.ovf != o) begin
        errors++;
        $display("FAIL out dut%0d got cyc %0d dout %0d ovf %0b want cyc %0d dout %0d ovf %0b",
                 i, cyc, got, o, e.cyc, e.val, e.ovf);
      end
    end
  endtask

  always @(posedge clk) begin
    logic ce_s;
    logic rst_s;
    ce_s  = ce;
    rst_s = ap_rst;
    cyc++;
    #1;
    if (!rst_s && ce_s) begin
      mon(0, vld0, dout0, ovf0);
      mon(1, vld1, dout1, ovf1);
      mon(2, vld2, dout2, ovf2);
    end
  end

  task automatic dchk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tap(input int a, input int b,
                     input bit m, input bit c, input bit l);
    @(negedge clk);
    ce       = 1'b1;
    in_vld   = 1'b1;
    din0     = a[15:0];
    din1     = b[7:0];
    mode     = m;
    acc_clr  = c;
    acc_last = l;
    issue    = cyc + 1;
  endtask

  // lat: enabled edges from the sampling edge to the visible strobe.
  task automatic expect3(input int lat, input int v0, input int v1,
                         input int v2, input bit o01, input bit o2);
    exp_t e;
    e.cyc = issue + lat;
    e.val = v0; e.ovf = o01; sb[0].push_back(e);
    e.val = v1; e.ovf = o01; sb[1].push_back(e);
    e.val = v2; e.ovf = o2;  sb[2].push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ce     = 1'b1;
      in_vld = 1'b0;
    end
  endtask

  task automatic stall(input int n, input bit ev, input int ed);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ce     = 1'b0;
      in_vld = 1'b0;
      dchk("stall_vld", int'(vld0), int'(ev));
      dchk("stall_dout", int'($signed(dout0)), ed);
    end
  endtask

  task automatic frame2;
    tap(100, 2, 1, 1, 0);
    tap(200, -1, 1, 0, 0);
    tap(-50, 3, 1, 0, 0);
    tap(7, 7, 1, 0, 1);
    expect3(2, -101, -101, -6, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    ap_rst   = 1'b1;
    ce       = 1'b1;
    in_vld   = 1'b0;
    din0     = '0;
    din1     = '0;
    mode     = 1'b0;
    acc_clr  = 1'b0;
    acc_last = 1'b0;
    repeat (3) @(negedge clk);
    dchk("rst_dout0", int'($signed(dout0)), 0);
    dchk("rst_dout1", int'($signed(dout1)), 0);
    dchk("rst_dout2", int'($signed(dout2)), 0);
    dchk("rst_vld", int'(vld0 | vld1 | vld2), 0);
    dchk("rst_ovf", int'(ovf0 | ovf1 | ovf2), 0);
    ap_rst = 1'b0;

    tap(1000, -3, 0, 0, 0);
    expect3(1, -3000, -3000, -187, 0, 0);
    tap(-32768, -128, 0, 0, 0);
    expect3(1, 4194304, 4194304, 262144, 0, 0);
    idle(4);

    frame2();
    idle(4);

    tap(10, 10, 1, 0, 1);
    expect3(2, -1, -1, 0, 0, 0);
    idle(4);

    tap(-32768, -128, 1, 1, 0);
    tap(-32768, -128, 1, 0, 0);
    tap(-32768, -128, 1, 0, 1);
    expect3(2, 8388607, -4194304, 786432, 1, 0);
    idle(4);

    tap(100, 2, 1, 1, 0);
    tap(200, -1, 1, 0, 0);
    stall(3, 0, 8388607);
    tap(-50, 3, 1, 0, 0);
    tap(7, 7, 1, 0, 1);
    expect3(2, -101, -101, -6, 0, 0);
    idle(4);

    tap(1000, -3, 0, 0, 0);
    expect3(1, -3000, -3000, -187, 0, 0);
    idle(1);
    stall(3, 1, -3000);
    idle(4);

    tap(100, 2, 1, 1, 0);
    tap(200, -1, 1, 0, 0);
    @(negedge clk);
    ap_rst = 1'b1;
    in_vld = 1'b0;
    @(negedge clk);
    ap_rst = 1'b0;
    dchk("mid_rst_dout0", int'($signed(dout0)), 0);
    dchk("mid_rst_dout2", int'($signed(dout2)), 0);
    dchk("mid_rst_vld", int'(vld0), 0);
    frame2();
    idle(4);

    tap(5, 5, 1, 1, 1);
    expect3(2, 25, 25, 2, 0, 0);
    idle(1);
    tap(2, 3, 0, 0, 0);
    expect3(1, 6, 6, 0, 0, 0);
    tap(5, 5, 1, 1, 1);
    expect3(2, 25, 25, 2, 0, 0);
    idle(4);

    tap(1000, 3, 0, 0, 0);
    expect3(1, 3000, 3000, 188, 0, 0);
    tap(1000, -3, 0, 0, 0);
    expect3(1, -3000, -3000, -187, 0, 0);
    tap(0, 5, 0, 0, 0);
    expect3(1, 0, 0, 0, 0, 0);
    idle(4);

    for (int i = 0; i < 30; i++) begin
      if (sb[0].size() + sb[1].size() + sb[2].size() == 0) break;
      idle(1);
    end
    dchk("drain_d0", sb[0].size(), 0);
    dchk("drain_d1", sb[1].size(), 0);
    dchk("drain_d2", sb[2].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
